// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster sequencer: position counters, active window, syncs, start pulses
//
// Purpose:
//   Walks the raster one pixel per pix_ce_i strobe and presents the
//   position, display-active flag and both syncs for that pixel. All of
//   these outputs are registered together, so they never skew.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset; parks the position on the last
//                  blanking pixel so the first strobe lands on (0,0)
//   pix_ce_i       pixel clock-enable
//   xcol_o/yrow_o  current column / row (11 bits)
//   disp_active    pixel lies in the visible area
//   hsync_o        horizontal sync, SYNC_POL level while asserted
//   vsync_o        vertical sync, SYNC_POL level while asserted
//   line_start_o   one-clk pulse when the column becomes 0
//   frame_start_o  one-clk pulse when the position becomes (0,0)
//   frame_cnt_o    frame counter
//
// Build option:
//   VGA_FRAME_CNT_EN  when defined, frame_cnt_o counts frame_start_o pulses
//                     (16 bits, wrapping); otherwise it is tied to zero.

module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pix_ce_i,
  output logic [10:0] xcol_o,
  output logic [10:0] yrow_o,
  output logic        disp_active,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        line_start_o,
  output logic        frame_start_o,
  output logic [15:0] frame_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // Window bounds are 12 bits so an end bound of exactly 2048 still compares correctly.
  localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG    = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG    = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [10:0] r_x;
  logic [10:0] r_y;
  logic        r_active;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_line_start;
  logic        r_frame_start;

  logic [10:0] w_nx;
  logic [10:0] w_ny;
  logic        w_x_wrap;
  logic        w_n_active;
  logic        w_n_hs_on;
  logic        w_n_vs_on;
  logic        w_n_line_start;
  logic        w_n_frame_start;

  // Next position and the attributes of that next pixel; everything below is
  // registered from the next position so all outputs describe the same pixel.
  always_comb begin
    w_x_wrap = (r_x == H_LAST);
    w_nx     = w_x_wrap ? 11'd0 : r_x + 11'd1;
    w_ny     = r_y;
    if (w_x_wrap) begin
      w_ny = (r_y == V_LAST) ? 11'd0 : r_y + 11'd1;
    end
    w_n_active      = ({1'b0, w_nx} < H_ACT_END) && ({1'b0, w_ny} < V_ACT_END);
    w_n_hs_on       = ({1'b0, w_nx} >= HS_BEG) && ({1'b0, w_nx} < HS_END);
    // y only changes when x wraps to 0, so vsync is line-granular by construction.
    w_n_vs_on       = ({1'b0, w_ny} >= VS_BEG) && ({1'b0, w_ny} < VS_END);
    w_n_line_start  = w_x_wrap;
    w_n_frame_start = w_x_wrap && (r_y == V_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_active      <= 1'b0;
      r_hsync       <= SYNC_OFF;
      r_vsync       <= SYNC_OFF;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_ce_i) begin
      r_x           <= w_nx;
      r_y           <= w_ny;
      r_active      <= w_n_active;
      r_hsync       <= w_n_hs_on ? SYNC_ON : SYNC_OFF;
      r_vsync       <= w_n_vs_on ? SYNC_ON : SYNC_OFF;
      r_line_start  <= w_n_line_start;
      r_frame_start <= w_n_frame_start;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Updates on the same edge that raises frame_start_o, so frame 1 reads 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame_cnt <= 16'h0000;
    end else if (pix_ce_i && w_n_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt_o = r_frame_cnt;
`else
  assign frame_cnt_o = 16'h0000;
`endif

  assign xcol_o        = r_x;
  assign yrow_o        = r_y;
  assign disp_active   = r_active;
  assign hsync_o       = r_hsync;
  assign vsync_o       = r_vsync;
  assign line_start_o  = r_line_start;
  assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - scoreboard bench for vga_timing_ctrl against a linear pixel-index model

module tb_vga_timing_ctrl;

  // Full-width horizontal timing; shortened vertical so whole frames fit the run.
  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PIX_PER_FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        pix_ce_i;
  logic [10:0] xcol_o;
  logic [10:0] yrow_o;
  logic        disp_active;
  logic        hsync_o;
  logic        vsync_o;
  logic        line_start_o;
  logic        frame_start_o;
  logic [15:0] frame_cnt_o;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .pix_ce_i     (pix_ce_i),
    .xcol_o       (xcol_o),
    .yrow_o       (yrow_o),
    .disp_active  (disp_active),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .line_start_o (line_start_o),
    .frame_start_o(frame_start_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Model state: raster position as a single index into the frame.
  int          m_lin;
  logic [15:0] m_fc;

  function automatic obs_t predict(int lin, logic ls, logic fs, logic [15:0] fc);
    obs_t o;
    int x, y;
    x = lin % HT;
    y = lin / HT;
    o.x   = 11'(x);
    o.y   = 11'(y);
    o.act = (x < HA) && (y < VA);
    o.hs  = !((x >= HA + HF) && (x < HA + HF + HS));
    o.vs  = !((y >= VA + VF) && (y < VA + VF + VS));
    o.ls  = ls;
    o.fs  = fs;
`ifdef VGA_FRAME_CNT_EN
    o.fc  = fc;
`else
    o.fc  = 16'h0000;
`endif
    return o;
  endfunction

  // Apply inputs for the coming edge, push the expected result of that edge, take the edge.
  task automatic drive(input logic r, input logic ce);
    logic ls, fs;
    rst_i    = r;
    pix_ce_i = ce;
    ls = 1'b0;
    fs = 1'b0;
    if (r) begin
      m_lin = PIX_PER_FRAME - 1;
      m_fc  = 16'h0000;
    end else if (ce) begin
      m_lin = (m_lin + 1) % PIX_PER_FRAME;
      ls = (m_lin % HT) == 0;
      fs = (m_lin == 0);
      if (fs) m_fc = m_fc + 16'd1;
    end
    exp_q.push_back(predict(m_lin, ls, fs, m_fc));
    @(posedge clk);
    #1;
  endtask

  // Monitor: one observation per clock, compared on the falling edge.
  initial begin
    obs_t got, want;
    @(posedge clk);
    forever begin
      @(negedge clk);
      got = '{x: xcol_o, y: yrow_o, act: disp_active, hs: hsync_o, vs: vsync_o,
              ls: line_start_o, fs: frame_start_o, fc: frame_cnt_o};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL scoreboard_empty t=%0t got x=%0d y=%0d but no expectation queued",
                 $time, got.x, got.y);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_errors++;
          $display("FAIL pixel t=%0t got x=%0d y=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d want x=%0d y=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                   $time, got.x, got.y, got.act, got.hs, got.vs, got.ls, got.fs, got.fc,
                   want.x, want.y, want.act, want.hs, want.vs, want.ls, want.fs, want.fc);
        end
      end
    end
  end

  initial begin
    m_lin = PIX_PER_FRAME - 1;
    m_fc  = 16'h0000;

    // Reset held with pix_ce_i high: reset must win.
    repeat (3) drive(1'b1, 1'b1);

    // Continuous strobes: a bit over three frames, covering every wrap.
    repeat (3 * PIX_PER_FRAME + 50) drive(1'b0, 1'b1);

    // Strobe on every 4th clock.
    for (int i = 0; i < 4000; i++) drive(1'b0, (i % 4) == 3);

    // Mid-frame reset at (300,3), then idle, then the first strobe lands on (0,0).
    for (int i = 0; i < PIX_PER_FRAME && m_lin != 3 * HT + 300; i++) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b1);

    // Random strobes with occasional resets.
    for (int i = 0; i < 6000; i++) begin
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) != 0));
    end

    // Finish with a clean frame wrap under continuous strobes.
    repeat (PIX_PER_FRAME + 10) drive(1'b0, 1'b1);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
